// File: rtl/nn_rgb_pkg.sv
// Shared types for the nn_rgb pixel path: the sideband bundle that rides alongside
// the NN datapath and the delay-pipe FSM state.
package nn_rgb_pkg;

   localparam int unsigned ADDR_W = 17;

   typedef struct packed {
      logic              vsync;
      logic              we;
      logic [ADDR_W-1:0] addr;
   } ctrl_sb_t;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } dly_state_e;

endpackage

// File: rtl/ctrl_sb_stage.sv
// One sideband pipeline stage: a ctrl_sb_t register plus its valid bit.
// clr_v wins over en so a flush drops the stage even while the pipe advances.
module ctrl_sb_stage
   import nn_rgb_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en,
   input  logic     clr_v,
   input  ctrl_sb_t d,
   input  logic     d_v,
   output ctrl_sb_t q,
   output logic     q_v
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         q_v <= 1'b0;
      end else begin
         if (en) begin
            q <= d;
         end
         if (clr_v) begin
            q_v <= 1'b0;
         end else if (en) begin
            q_v <= d_v;
         end
      end
   end

endmodule

// File: rtl/ctrl_delay_pipe.sv
// Run-time selectable sideband delay pipe for the nn_rgb path: keeps vsync/we/addr
// aligned with the pixel result, holds on stall and flushes on a delay change.
module ctrl_delay_pipe #(
   parameter int unsigned ADDR_W        = nn_rgb_pkg::ADDR_W,
   parameter int unsigned MAX_DELAY     = 16,
   parameter int unsigned DEFAULT_DELAY = 7,
   parameter int unsigned DLY_W         = $clog2(MAX_DELAY + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              dly_load_i,
   input  logic [DLY_W-1:0]  dly_sel_i,
   input  logic              vsync_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   output logic              vsync_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              we_o,
   output logic              valid_o,
   output logic              busy_o,
   output logic [DLY_W-1:0]  cur_dly_o
);

   import nn_rgb_pkg::*;

   ctrl_sb_t   sb_in;
   ctrl_sb_t   sb_q     [MAX_DELAY];
   logic       v_q      [MAX_DELAY];
   ctrl_sb_t   sb_d     [MAX_DELAY];
   logic       v_d      [MAX_DELAY];
   logic       clr_v    [MAX_DELAY];

   ctrl_sb_t   tap;
   logic       tap_v;

   dly_state_e state_q, state_d;
   logic [DLY_W-1:0] cur_dly_q, cur_dly_d;
   logic [DLY_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [DLY_W-1:0] dly_clamped;
   logic             fill_done;

   assign sb_in.vsync = vsync_i;
   assign sb_in.we    = we_i;
   assign sb_in.addr  = addr_i;

   // Stage 0 takes fresh input; a load with the pipe stalled must still drop its v.
   always_comb begin
      sb_d[0]  = sb_in;
      v_d[0]   = 1'b1;
      clr_v[0] = dly_load_i & ~en_i;
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
         sb_d[i]  = sb_q[i-1];
         v_d[i]   = v_q[i-1];
         clr_v[i] = dly_load_i;
      end
   end

   for (genvar i = 0; i < int'(MAX_DELAY); i++) begin : g_stage
      ctrl_sb_stage u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en_i),
         .clr_v (clr_v[i]),
         .d     (sb_d[i]),
         .d_v   (v_d[i]),
         .q     (sb_q[i]),
         .q_v   (v_q[i])
      );
   end

   always_comb begin
      if (dly_sel_i == '0) begin
         dly_clamped = DLY_W'(1);
      end else if (dly_sel_i > DLY_W'(MAX_DELAY)) begin
         dly_clamped = DLY_W'(MAX_DELAY);
      end else begin
         dly_clamped = dly_sel_i;
      end
   end

   assign fill_done = (fill_cnt_q == cur_dly_q - DLY_W'(1));

   // A load takes priority over fill completion in the same cycle.
   always_comb begin
      state_d    = state_q;
      cur_dly_d  = cur_dly_q;
      fill_cnt_d = fill_cnt_q;
      if (dly_load_i) begin
         cur_dly_d  = dly_clamped;
         fill_cnt_d = en_i ? DLY_W'(1) : '0;
         state_d    = (en_i && dly_clamped == DLY_W'(1)) ? RUN : FILL;
      end else if (en_i && state_q == FILL) begin
         if (fill_done) begin
            state_d    = RUN;
            fill_cnt_d = '0;
         end else begin
            fill_cnt_d = fill_cnt_q + DLY_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         cur_dly_q  <= DLY_W'(DEFAULT_DELAY);
         fill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_dly_q  <= cur_dly_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   always_comb begin
      tap   = '0;
      tap_v = 1'b0;
      for (int i = 0; i < int'(MAX_DELAY); i++) begin
         if (cur_dly_q == DLY_W'(i + 1)) begin
            tap   = sb_q[i];
            tap_v = v_q[i];
         end
      end
   end

   assign vsync_o   = tap.vsync & tap_v;
   assign we_o      = tap.we & tap_v;
   assign addr_o    = tap.addr;
   assign valid_o   = tap_v;
   assign busy_o    = (state_q == FILL);
   assign cur_dly_o = cur_dly_q;

endmodule
